// File: rtl/ni_packetizer_pkg.sv
// Shared NI definitions: flit type codes, packetizer FSM states and credit counter width.
// The lwnet-side depacketizer imports the same package so both ends agree on encodings.
package ni_packetizer_pkg;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  localparam int unsigned CreditWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StHead = 2'b01,
    StTail = 2'b10
  } ni_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Router-side credit tracker for flit injection.
// Starts full, decrements per issued flit, increments per returned credit, saturating at CREDITS.
module ni_credit_counter #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic credit_in,
  output logic has_credit,
  output logic credit_err
);

  localparam logic [WIDTH-1:0] MaxCredits = WIDTH'(CREDITS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             at_max;

  assign at_max     = (cnt_q == MaxCredits);
  assign has_credit = (cnt_q != '0);
  assign credit_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    // A returned credit with every slot already free means the router over-reported.
    if (credit_in && at_max) begin
      err_d = 1'b1;
    end
    if (consume && !credit_in) begin
      cnt_d = cnt_q - 1'b1;
    end else if (credit_in && !consume && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= MaxCredits;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// Turns swnet address/data writes into HEAD/TAIL flit pairs for the local router port.
// A 2-entry queue decouples swnet from credit stalls; the FSM never interleaves packets.
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter int unsigned MSB_SLOT = 5,
  parameter int unsigned CREDITS  = 4,
  parameter logic [(1 << (MSB_SLOT - 2))-1:0] SRC_ID = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ni_write_en,
  input  logic [(1 << (MSB_SLOT-1))-1:0] ni_waddr,
  input  logic [(1 << (MSB_SLOT-1))-1:0] ni_wdata,
  output logic                           ni_wfull,
  output logic [(1 << MSB_SLOT)-1:0]     flit_out,
  output logic [1:0]                     flit_type,
  output logic                           flit_valid,
  input  logic                           credit_in,
  output logic                           ovf_err,
  output logic                           credit_err
);

  localparam int unsigned DSIZE = 1 << MSB_SLOT;
  localparam int unsigned RSIZE = 1 << (MSB_SLOT - 1);
  localparam int unsigned HSIZE = RSIZE / 2;

  logic [RSIZE-1:0] addr_mem [2];
  logic [RSIZE-1:0] data_mem [2];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             ovf_err_q, ovf_err_d;

  ni_state_e        state_q, state_d;
  logic [HSIZE-1:0] seq_q, seq_d;
  logic [DSIZE-1:0] flit_out_q, flit_out_d;
  logic [1:0]       flit_type_q, flit_type_d;
  logic             flit_valid_q, flit_valid_d;

  logic             push, pop, issue, has_credit;
  logic [RSIZE-1:0] head_addr, head_data;

  assign ni_wfull  = (count_q == 2'd2);
  assign push      = ni_write_en && !ni_wfull;
  // Issue/pop depend only on registered state so the queue and FSM logic form no loop.
  assign issue     = has_credit && ((state_q == StHead) || (state_q == StTail));
  assign pop       = has_credit && (state_q == StTail);
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  ni_credit_counter #(
    .CREDITS(CREDITS),
    .WIDTH  (CreditWidth)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .consume   (issue),
    .credit_in (credit_in),
    .has_credit(has_credit),
    .credit_err(credit_err)
  );

  always_comb begin
    count_d   = count_q + 2'(push) - 2'(pop);
    rd_ptr_d  = rd_ptr_q ^ pop;
    wr_ptr_d  = wr_ptr_q ^ push;
    ovf_err_d = ovf_err_q | (ni_write_en & ni_wfull);
  end

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    flit_out_d   = flit_out_q;
    flit_type_d  = FLIT_IDLE;
    flit_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0) state_d = StHead;
      end
      StHead: begin
        if (has_credit) begin
          flit_valid_d = 1'b1;
          flit_type_d  = FLIT_HEAD;
          flit_out_d   = {head_addr[RSIZE-1:HSIZE], SRC_ID, head_addr[HSIZE-1:0], seq_q};
          state_d      = StTail;
        end
      end
      StTail: begin
        if (has_credit) begin
          flit_valid_d = 1'b1;
          flit_type_d  = FLIT_TAIL;
          flit_out_d   = {seq_q, {HSIZE{1'b0}}, head_data};
          seq_d        = seq_q + 1'b1;
          state_d      = (count_d != 2'd0) ? StHead : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= ni_waddr;
      data_mem[wr_ptr_q] <= ni_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      ovf_err_q    <= 1'b0;
      state_q      <= StIdle;
      seq_q        <= '0;
      flit_out_q   <= '0;
      flit_type_q  <= FLIT_IDLE;
      flit_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      ovf_err_q    <= ovf_err_d;
      state_q      <= state_d;
      seq_q        <= seq_d;
      flit_out_q   <= flit_out_d;
      flit_type_q  <= flit_type_d;
      flit_valid_q <= flit_valid_d;
    end
  end

  assign flit_out   = flit_out_q;
  assign flit_type  = flit_type_q;
  assign flit_valid = flit_valid_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Sits directly downstream of the core-side write network (swnet) on the NoC side of the network interface.
- Consumes its {ni_waddr, ni_wdata, ni_write_en} stream and drives the ni_wfull backpressure back to it.
- Turns each address/data pair into a 2-flit packet (HEAD, TAIL) and injects it into the local router port.
- Injection uses credit-based flow control.

Parameters:
- MSB_SLOT, 5, log2 of flit width. DSIZE = 1<<MSB_SLOT (32), RSIZE = 1<<(MSB_SLOT-1) (16), HSIZE = RSIZE/2 (8).
- CREDITS, 4, router input-buffer depth. Initial credit count. Range 1..15.
- SRC_ID, 8'h00, this node's router address (HSIZE bits), placed in HEAD flits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ni_write_en  in  1  write strobe from swnet. One entry per cycle high.
- ni_waddr  in  RSIZE  [RSIZE-1:HSIZE] = destination router, [HSIZE-1:0] = neuron address.
- ni_wdata  in  RSIZE  payload.
- ni_wfull  out  1  input queue full. Combinational from registered occupancy.
- flit_out  out  DSIZE  flit to router. Registered.
- flit_type  out  2  2'b01 = HEAD, 2'b10 = TAIL, 2'b00 = idle. Registered.
- flit_valid  out  1  flit_out/flit_type valid this cycle. Registered.
- credit_in  in  1  one-cycle pulse; router freed one buffer slot.
- ovf_err  out  1  sticky: write attempted while ni_wfull=1.
- credit_err  out  1  sticky: credit_in received while counter == CREDITS.

Behaviour:
- Reset (async, active-high). All outputs go to 0: flit_out, flit_type, flit_valid, ovf_err, credit_err. ni_wfull=0. Queue empty. seq=0. Credit counter=CREDITS. FSM=IDLE.
- Input queue:
  - 2-entry FIFO of {waddr, wdata} with a 2-bit count. ni_wfull = (count==2).
  - Push when ni_write_en && !ni_wfull.
  - Write while full: dropped, ovf_err<=1, queue unchanged.
  - Push and pop in the same cycle are both performed.
- Flit formats:
  - HEAD = {dest[HSIZE], SRC_ID, neuron[HSIZE], seq[HSIZE]}.
  - TAIL = {seq[HSIZE], HSIZE'h0, wdata[RSIZE]}.
  - seq is an 8-bit packet counter. Increments on TAIL issue; wraps 8'hFF -> 8'h00.
- Credit counter:
  - Width 4 bits.
  - Decrements on each flit issue. Increments on credit_in. Both in the same cycle: unchanged.
  - credit_in at CREDITS: count saturates, credit_err<=1.
  - A flit may issue only when the counter > 0, evaluated on the registered value.
- FSM (registered outputs; flit_valid<=0 on any edge that issues no flit):
  - IDLE: queue nonempty -> HEAD.
  - HEAD: if credits>0, issue the HEAD of the queue-head entry (flit_valid<=1, flit_type<=01), then -> TAIL. Otherwise stay; no flit.
  - TAIL: if credits>0, issue TAIL (type 10), pop the entry, seq++. Next state is HEAD if count after pop/push > 0, else IDLE. Otherwise stay.
- Latency:
  - Write accepted at edge N: FSM reaches HEAD at edge N+1, HEAD flit_valid at edge N+2, TAIL at edge N+3.
  - Back-to-back packets with credits available: one flit per cycle, no bubbles between a TAIL and the next HEAD.
- Packets are never interleaved. A HEAD is always followed by its TAIL before any other HEAD.
- Stall with credits=0 mid-packet (between HEAD and TAIL) holds state; flit_valid=0 until a credit returns.
- ni_wfull deasserts the cycle after the pop edge.

Decomposition:
- Shared header ni_defs.vh: flit type codes (FLIT_IDLE=2'b00, FLIT_HEAD=2'b01, FLIT_TAIL=2'b10), FSM state encodings, HEAD/TAIL field offset macros derived from MSB_SLOT. The future depacketizer on the lwnet side includes the same header.
- One sub-module, ni_credit_counter (params CREDITS, width 4). Ports: clk, reset, consume, credit_in, has_credit, credit_err.
- Queue and FSM stay in ni_packetizer.

Test Plan:
- Reset then single write waddr=16'h0305, wdata=16'hBEEF, SRC_ID=8'h01 -> 2 cycles later HEAD 32'h03010500 (type 01); next cycle TAIL 32'h0000BEEF (type 10); seq becomes 1.
- Three back-to-back writes with CREDITS=4 and no credit_in -> ni_wfull high after 2nd accepted; 3rd write (held until ~wfull) proceeds; exactly 4 flits issue then flit_valid stays 0; credit_in pulses resume TAIL/HEAD in order.
- Write while ni_wfull=1 -> entry dropped, ovf_err=1 sticky, packet stream shows only accepted entries.
- credit_in pulse with counter=CREDITS -> credit_err=1, count stays 4; simultaneous issue+credit_in -> count unchanged.
- 256 packets -> seq field wraps FF->00 in both HEAD and TAIL.
- Assert reset mid-packet (after HEAD, before TAIL) -> all outputs 0 immediately (async), credits=CREDITS, queue empty, next write starts with HEAD, seq=0.
